// File: rtl/q_learn_pkg.sv
// q_learn_pkg: shared widths, action encoding, LFSR taps and FP32 compare helpers
package q_learn_pkg;
  localparam int ADDR_S_WIDTH = 16;
  localparam int ADDR_Q_WIDTH = 19;
  localparam int DATA_WIDTH = 32;
  localparam logic [2:0] A_L = 3'd0;
  localparam logic [2:0] A_LU = 3'd1;
  localparam logic [2:0] A_U = 3'd2;
  localparam logic [2:0] A_UR = 3'd3;
  localparam logic [2:0] A_R = 3'd4;
  localparam logic [2:0] A_RD = 3'd5;
  localparam logic [2:0] A_D = 3'd6;
  localparam logic [2:0] A_DL = 3'd7;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [2:0] {IDLE, DECIDE, READ, DRAIN, OUT} sel_state_t;
  // -0 is folded onto +0 so both zeros map to the same key
  function automatic logic [31:0] fp32_key(input logic [31:0] b);
    logic [31:0] z;
    z = (b[30:0] == 31'd0) ? 32'd0 : b;
    return z[31] ? ~z : z ^ 32'h8000_0000;
  endfunction
  function automatic logic fp32_is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0);
  endfunction
endpackage

// File: rtl/action_selector_if.sv
// action_selector_if: state offer, Q-table read port and action handshake
interface action_selector_if;
  import q_learn_pkg::*;
  logic [ADDR_S_WIDTH-1:0] state_i;
  logic state_valid;
  logic state_ready;
  logic [15:0] epsilon_thr;
  logic q_rd_en;
  logic [ADDR_Q_WIDTH-1:0] q_rd_addr;
  logic [DATA_WIDTH-1:0] q_rd_data;
  logic [2:0] action_o;
  logic action_valid;
  logic action_ready;
  logic explore_o;
  logic [31:0] explore_cnt;
  modport master (
    output state_i, state_valid, epsilon_thr, q_rd_data, action_ready,
    input state_ready, q_rd_en, q_rd_addr, action_o, action_valid, explore_o, explore_cnt
  );
  modport slave (
    input state_i, state_valid, epsilon_thr, q_rd_data, action_ready,
    output state_ready, q_rd_en, q_rd_addr, action_o, action_valid, explore_o, explore_cnt
  );
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR that advances only when step is high
module lfsr16
  import q_learn_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic [15:0] value
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= SEED;
    else if (step) value <= lfsr16_next(value);
endmodule

// File: rtl/action_selector.sv
// action_selector: epsilon-greedy action choice, random explore or argmax over Q(s,0..7)
module action_selector
  import q_learn_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  action_selector_if.slave bus
);
  sel_state_t st;
  logic [ADDR_S_WIDTH-1:0] s_q;
  logic [15:0] thr_q, lfsr, lfsr_nxt;
  logic [2:0] cnt, best_a;
  logic [31:0] best_key, key;
  logic best_v, exp_q, hit;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0][2:0] tag_a;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .step(st == DECIDE), .value(lfsr));
  assign lfsr_nxt = lfsr16_next(lfsr);
  assign key = fp32_key(bus.q_rd_data);
  assign hit = tag_v[RD_LAT-1] && !fp32_is_nan(bus.q_rd_data) && (!best_v || key > best_key);
  // index delay line: tags each returning Q value with the action it was read for
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag_v <= '0;
      tag_a <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_a[i] <= tag_a[i-1];
      end
      tag_v[0] <= bus.q_rd_en;
      tag_a[0] <= bus.q_rd_addr[2:0];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      s_q <= '0;
      thr_q <= '0;
      cnt <= '0;
      best_a <= '0;
      best_key <= '0;
      best_v <= 1'b0;
      exp_q <= 1'b0;
      bus.state_ready <= 1'b1;
      bus.q_rd_en <= 1'b0;
      bus.q_rd_addr <= '0;
      bus.action_o <= '0;
      bus.action_valid <= 1'b0;
      bus.explore_o <= 1'b0;
      bus.explore_cnt <= '0;
    end else begin
      case (st)
        IDLE:
          if (bus.state_valid) begin
            s_q <= bus.state_i;
            thr_q <= bus.epsilon_thr;
            bus.state_ready <= 1'b0;
            best_v <= 1'b0;
            best_a <= '0;
            st <= DECIDE;
          end
        DECIDE:
          if (lfsr_nxt <= thr_q) begin
            exp_q <= 1'b1;
            best_a <= lfsr_nxt[2:0];
            st <= OUT;
          end else begin
            exp_q <= 1'b0;
            bus.q_rd_en <= 1'b1;
            bus.q_rd_addr <= {s_q, 3'd0};
            st <= READ;
          end
        READ:
          if (bus.q_rd_addr[2:0] == 3'd7) begin
            bus.q_rd_en <= 1'b0;
            cnt <= '0;
            st <= DRAIN;
          end else bus.q_rd_addr[2:0] <= bus.q_rd_addr[2:0] + 3'd1;
        DRAIN:
          if (cnt == 3'(RD_LAT - 1)) st <= OUT;
          else cnt <= cnt + 3'd1;
        OUT:
          // first OUT cycle latches the final choice, then it is offered until taken
          if (!bus.action_valid) begin
            bus.action_valid <= 1'b1;
            bus.action_o <= best_a;
            bus.explore_o <= exp_q;
          end else if (bus.action_ready) begin
            bus.action_valid <= 1'b0;
            bus.state_ready <= 1'b1;
            bus.explore_cnt <= bus.explore_cnt + {31'd0, bus.explore_o};
            st <= IDLE;
          end
        default: st <= IDLE;
      endcase
      if (hit) begin
        best_v <= 1'b1;
        best_key <= key;
        best_a <= tag_a[RD_LAT-1];
      end
    end
endmodule

// File: tb/tb_action_selector.sv
// tb_action_selector: directed checks of explore/greedy choice, latency, stall and reset abort
module tb_action_selector;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] state_i = '0, thr = '0;
  logic state_valid = 1'b0, action_ready = 1'b0;
  action_selector_if bus1 ();
  action_selector_if bus3 ();
  assign bus1.state_i = state_i;
  assign bus1.state_valid = state_valid;
  assign bus1.epsilon_thr = thr;
  assign bus1.action_ready = action_ready;
  assign bus3.state_i = state_i;
  assign bus3.state_valid = state_valid;
  assign bus3.epsilon_thr = thr;
  assign bus3.action_ready = action_ready;
  action_selector #(.RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  action_selector #(.RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  logic [31:0] qmem [8];
  logic [15:0] qstate = '0;
  logic [31:0] p1, p3 [3];
  // wrong-state or unstrobed reads return a large positive value that would win if used
  function automatic logic [31:0] qlook(input logic en, input logic [18:0] a);
    return (en && a[18:3] == qstate) ? qmem[a[2:0]] : 32'h7F00_0000;
  endfunction
  always @(posedge clk) begin
    p1 <= qlook(bus1.q_rd_en, bus1.q_rd_addr);
    p3[0] <= qlook(bus3.q_rd_en, bus3.q_rd_addr);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.q_rd_data = p1;
  assign bus3.q_rd_data = p3[2];
  logic [18:0] addr_q [$];
  int n_rd3;
  always @(posedge clk) begin
    if (bus1.q_rd_en) addr_q.push_back(bus1.q_rd_addr);
    if (bus3.q_rd_en) n_rd3 = n_rd3 + 1;
  end
  int n_chk = 0, n_fail = 0;
  logic [15:0] lfsr_m;
  logic [31:0] cnt_m;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0);
  endfunction
  task automatic decide(input string tag, input logic [15:0] s, input logic [15:0] t,
                        input bit exp_x, input logic [2:0] exp_g, input int hold);
    int lat1, lat3;
    logic [2:0] ea;
    addr_q.delete();
    n_rd3 = 0;
    @(negedge clk);
    state_i = s;
    thr = t;
    state_valid = 1'b1;
    @(posedge clk);
    #1 state_valid = 1'b0;
    state_i = ~s;
    thr = ~t;
    lfsr_m = lstep(lfsr_m);
    ea = exp_x ? lfsr_m[2:0] : exp_g;
    lat1 = 0;
    lat3 = 0;
    for (int c = 1; c <= 40 && (lat1 == 0 || lat3 == 0); c++) begin
      @(posedge clk);
      #1;
      if (c == 1) check({tag, ".busy"}, bus1.state_ready, 1'b0);
      if (lat1 == 0 && bus1.action_valid) lat1 = c;
      if (lat3 == 0 && bus3.action_valid) lat3 = c;
    end
    check({tag, ".lat1"}, lat1, exp_x ? 2 : 11);
    check({tag, ".lat3"}, lat3, exp_x ? 2 : 13);
    check({tag, ".act1"}, bus1.action_o, ea);
    check({tag, ".act3"}, bus3.action_o, ea);
    check({tag, ".exp1"}, bus1.explore_o, exp_x);
    check({tag, ".exp3"}, bus3.explore_o, exp_x);
    check({tag, ".nrd1"}, addr_q.size(), exp_x ? 0 : 8);
    check({tag, ".nrd3"}, n_rd3, exp_x ? 0 : 8);
    for (int i = 0; i < addr_q.size(); i++) check({tag, ".addr"}, addr_q[i], {s, 3'(i)});
    if (hold > 0) state_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_v"}, bus1.action_valid, 1'b1);
      check({tag, ".hold_a"}, bus1.action_o, ea);
      check({tag, ".hold_x"}, bus1.explore_o, exp_x);
      check({tag, ".hold_rdy"}, bus1.state_ready, 1'b0);
      check({tag, ".hold_rd"}, bus1.q_rd_en, 1'b0);
      check({tag, ".hold_lfsr"}, dut1.u_lfsr.value, lfsr_m);
    end
    @(negedge clk);
    state_valid = 1'b0;
    action_ready = 1'b1;
    @(posedge clk);
    #1 action_ready = 1'b0;
    if (exp_x) cnt_m = cnt_m + 1;
    check({tag, ".done1"}, {bus1.action_valid, bus1.state_ready}, 2'b01);
    check({tag, ".done3"}, {bus3.action_valid, bus3.state_ready}, 2'b01);
    check({tag, ".cnt1"}, bus1.explore_cnt, cnt_m);
    check({tag, ".cnt3"}, bus3.explore_cnt, cnt_m);
    check({tag, ".lfsr3"}, dut3.u_lfsr.value, lfsr_m);
  endtask
  initial begin
    bit hit4;
    lfsr_m = 16'hACE1;
    cnt_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", {bus1.state_ready, bus3.state_ready}, 2'b11);
    check("rst.outs", {bus1.action_valid, bus1.q_rd_en, bus1.explore_o, bus1.action_o}, 6'd0);
    check("rst.cnt", bus1.explore_cnt, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    decide("s1", 16'h0000, 16'hFFFF, 1'b1, 3'd0, 0);
    check("s1.lfsr_hand", dut1.u_lfsr.value, 16'hE270);
    check("s1.act_hand", bus1.action_o, 3'd0);
    qstate = 16'h1234;
    qmem = '{32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
             32'h4080_0000, 32'h4118_0000, 32'h40C0_0000, 32'h40E0_0000};
    decide("s2", 16'h1234, 16'h0000, 1'b0, 3'd5, 0);
    qstate = 16'h0101;
    qmem = '{32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF00_0000,
             32'hBF80_0000, 32'hBF80_0000, 32'hBF00_0000, 32'hBF80_0000};
    decide("s3tie", 16'h0101, 16'h0000, 1'b0, 3'd3, 0);
    qmem = '{32'h7FC0_0000, 32'hFFC0_0000, 32'h7F80_0001, 32'hFF80_0001,
             32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FC0_0001, 32'h7FC1_2345};
    decide("s3nan", 16'h0101, 16'h0000, 1'b0, 3'd0, 0);
    qmem = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    decide("s3zero", 16'h0101, 16'h0000, 1'b0, 3'd0, 0);
    qmem = '{32'hFF80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
             32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h7FC0_0000};
    decide("s3nan7", 16'h0101, 16'h0000, 1'b0, 3'd6, 0);
    qmem = '{32'hC000_0000, 32'hC040_0000, 32'h3F00_0000, 32'hBF00_0000,
             32'h3E80_0000, 32'hFF80_0000, 32'h8000_0000, 32'h3F00_0000};
    decide("s3sign", 16'h0101, 16'h0000, 1'b0, 3'd2, 0);
    decide("s4", 16'h5555, 16'hFFFF, 1'b1, 3'd0, 20);
    qstate = 16'h00AB;
    @(negedge clk);
    state_i = 16'h00AB;
    thr = 16'h0000;
    state_valid = 1'b1;
    @(posedge clk);
    #1 state_valid = 1'b0;
    hit4 = 1'b0;
    for (int c = 0; c < 40 && !hit4; c++) begin
      @(posedge clk);
      #1 hit4 = bus1.q_rd_en && bus1.q_rd_addr[2:0] == 3'd4;
    end
    check("s5.reach_a4", hit4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("s5.clr1", {bus1.state_ready, bus1.action_valid, bus1.q_rd_en, bus1.explore_o}, 4'b1000);
    check("s5.clr3", {bus3.state_ready, bus3.action_valid, bus3.q_rd_en, bus3.explore_o}, 4'b1000);
    check("s5.cnt", bus1.explore_cnt, 32'd0);
    check("s5.lfsr1", dut1.u_lfsr.value, 16'hACE1);
    check("s5.lfsr3", dut3.u_lfsr.value, 16'hACE1);
    @(negedge clk) rst_n = 1'b1;
    lfsr_m = 16'hACE1;
    cnt_m = '0;
    decide("s5re", 16'h0000, 16'hFFFF, 1'b1, 3'd0, 0);
    check("s5re.lfsr_hand", dut1.u_lfsr.value, 16'hE270);
    check("s5re.act_hand", bus1.action_o, 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
